// File: rtl/functw_share_sched.sv
// functw_share_sched
//   Round-robin scheduler that time-shares one W(I) scale-factor lookup
//   among NCH ADPCM channels. Each granted channel's quantizer code and
//   its configured rate are presented to the shared lookup. The lookup
//   result is returned one cycle later with a one-hot acknowledge.
//
// Handshake: REQ[k] rises with a stable I_BUS slice and stays high until
//   ACK[k] pulses. It drops the cycle after ACK. ACK coincides with VALID.
//   A channel still held in either pipeline stage is never regranted, so a
//   REQ that is still high during its own ACK cycle is not served twice.
//
// Ports
//   CLK, RESET_N      clock (rising edge), async active-low reset
//   REQ[NCH]          per-channel request
//   I_BUS[5*NCH]      quantizer codes, channel k at [5k+4:5k]
//   CFG_WE/CH/RATE    rate register write (00=40k 01=32k 10=24k 11=16k)
//   F_I, F_RATE       registered code/rate to the shared lookup
//   F_WI              combinational lookup result for F_I/F_RATE
//   WI_OUT, CH_OUT    registered result and owning channel
//   VALID, ACK[NCH]   one-cycle result strobe and one-hot acknowledge
//   BUSY              either pipeline stage holds a transaction
module functw_share_sched #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NCH-1:0]     REQ,
  input  logic [5*NCH-1:0]   I_BUS,
  input  logic               CFG_WE,
  input  logic [CHW-1:0]     CFG_CH,
  input  logic [1:0]         CFG_RATE,
  output logic [4:0]         F_I,
  output logic [1:0]         F_RATE,
  input  logic [11:0]        F_WI,
  output logic [11:0]        WI_OUT,
  output logic [CHW-1:0]     CH_OUT,
  output logic               VALID,
  output logic [NCH-1:0]     ACK,
  output logic               BUSY
);

  localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

  logic [1:0]     r_rate [NCH];
  logic [CHW-1:0] r_ptr;
  logic           r_s1_vld;
  logic [CHW-1:0] r_s1_ch;
  logic [4:0]     r_f_i;
  logic [1:0]     r_f_rate;
  logic           r_s2_vld;
  logic [CHW-1:0] r_s2_ch;
  logic [11:0]    r_wi;
  logic [NCH-1:0] r_ack;

  logic [4:0]     w_code [NCH];
  logic [NCH-1:0] w_s1_mask;
  logic [NCH-1:0] w_s2_mask;
  logic [NCH-1:0] w_elig;
  logic           w_gnt_vld;
  logic [CHW-1:0] w_gnt_ch;

  for (genvar k = 0; k < NCH; k++) begin : g_code
    assign w_code[k] = I_BUS[5*k +: 5];
  end

  // Channels occupying stage 1 or stage 2 are masked out of arbitration.
  always_comb begin
    w_s1_mask = r_s1_vld ? (NCH'(1) << r_s1_ch) : '0;
    w_s2_mask = r_s2_vld ? (NCH'(1) << r_s2_ch) : '0;
    w_elig    = REQ & ~w_s1_mask & ~w_s2_mask;
  end

  // First eligible channel at or after the pointer, wrapping modulo NCH.
  always_comb begin : rr_pick
    logic [CHW:0] v_sum;
    v_sum     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int i = 0; i < NCH; i++) begin
      v_sum = {1'b0, r_ptr} + (CHW+1)'(i);
      if (v_sum >= NCH_L) v_sum = v_sum - NCH_L;
      if (!w_gnt_vld && w_elig[v_sum[CHW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = v_sum[CHW-1:0];
      end
    end
  end

  // Rate registers: a grant on the same edge reads the old value.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < NCH; k++) r_rate[k] <= 2'b00;
    end else if (CFG_WE && ({1'b0, CFG_CH} < NCH_L)) begin
      r_rate[CFG_CH] <= CFG_RATE;
    end
  end

  // Stage 1: grant and present code/rate to the shared lookup.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ptr    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_ch  <= '0;
      r_f_i    <= '0;
      r_f_rate <= '0;
    end else begin
      r_s1_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s1_ch  <= w_gnt_ch;
        r_f_i    <= w_code[w_gnt_ch];
        r_f_rate <= r_rate[w_gnt_ch];
        r_ptr    <= (w_gnt_ch == CHW'(NCH-1)) ? '0 : w_gnt_ch + 1'b1;
      end
    end
  end

  // Stage 2: capture the lookup result; WI_OUT/CH_OUT hold between results.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s2_vld <= 1'b0;
      r_s2_ch  <= '0;
      r_wi     <= '0;
      r_ack    <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_ack    <= r_s1_vld ? (NCH'(1) << r_s1_ch) : '0;
      if (r_s1_vld) begin
        r_s2_ch <= r_s1_ch;
        r_wi    <= F_WI;
      end
    end
  end

  assign F_I    = r_f_i;
  assign F_RATE = r_f_rate;
  assign WI_OUT = r_wi;
  assign CH_OUT = r_s2_ch;
  assign VALID  = r_s2_vld;
  assign ACK    = r_ack;
  assign BUSY   = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_functw_share_sched.sv
// tb_functw_share_sched
//   Bench for functw_share_sched. The bench plays the shared W(I) lookup
//   (G.726 tables with sign folding) and the requesting channels. Requests
//   push {channel, expected W(I)} into a scoreboard; a monitor matches every
//   VALID against it. Directed sequences check latency, ordering and reset.
module tb_functw_share_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int W   = CHW + 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]   req;
  logic [5*NCH-1:0] i_bus;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_rate;
  logic [4:0]       f_i;
  logic [1:0]       f_rate;
  logic [11:0]      f_wi;
  logic [11:0]      wi_out;
  logic [CHW-1:0]   ch_out;
  logic             valid;
  logic [NCH-1:0]   ack;
  logic             busy;

  logic             req_a   [NCH];
  logic [4:0]       i_bus_a [NCH];
  logic [1:0]       rate_model [NCH];

  logic [W-1:0]     exp_q[$];
  int               ack_log[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               mon_idx;

  functw_share_sched #(.NCH(NCH)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .I_BUS(i_bus),
    .CFG_WE(cfg_we), .CFG_CH(cfg_ch), .CFG_RATE(cfg_rate),
    .F_I(f_i), .F_RATE(f_rate), .F_WI(f_wi),
    .WI_OUT(wi_out), .CH_OUT(ch_out), .VALID(valid), .ACK(ack), .BUSY(busy)
  );

  always_comb begin
    req   = '0;
    i_bus = '0;
    for (int k = 0; k < NCH; k++) begin
      req[k]          = req_a[k];
      i_bus[5*k +: 5] = i_bus_a[k];
    end
  end

  // Shared lookup model: G.726 W(I) tables, magnitude folded from the sign bit.
  function automatic logic [11:0] lut(input logic [1:0] rate, input logic [4:0] i);
    logic [3:0] idx;
    logic [11:0] r;
    idx = '0;
    r   = '0;
    case (rate)
      2'b00: begin
        idx = i[4] ? ~i[3:0] : i[3:0];
        case (idx)
          4'd0: r = 12'd14;   4'd1: r = 12'd14;   4'd2: r = 12'd24;   4'd3: r = 12'd39;
          4'd4: r = 12'd40;   4'd5: r = 12'd41;   4'd6: r = 12'd58;   4'd7: r = 12'd100;
          4'd8: r = 12'd141;  4'd9: r = 12'd179;  4'd10: r = 12'd219; 4'd11: r = 12'd280;
          4'd12: r = 12'd358; 4'd13: r = 12'd440; 4'd14: r = 12'd529; default: r = 12'd696;
        endcase
      end
      2'b01: begin
        idx = {1'b0, (i[3] ? ~i[2:0] : i[2:0])};
        case (idx)
          4'd0: r = 12'hFF4;  4'd1: r = 12'd18;   4'd2: r = 12'd41;   4'd3: r = 12'd64;
          4'd4: r = 12'd112;  4'd5: r = 12'd198;  4'd6: r = 12'd355;  default: r = 12'd1122;
        endcase
      end
      2'b10: begin
        idx = {2'b00, (i[2] ? ~i[1:0] : i[1:0])};
        case (idx)
          4'd0: r = 12'hFFC;  4'd1: r = 12'd30;   4'd2: r = 12'd137;  default: r = 12'd582;
        endcase
      end
      default: begin
        idx = {3'b000, (i[1] ? ~i[0] : i[0])};
        r = (idx == 4'd0) ? 12'hFEA : 12'd439;
      end
    endcase
    return r;
  endfunction

  always_comb f_wi = lut(f_rate, f_i);

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid) begin
        mon_idx = -1;
        foreach (exp_q[i])
          if (mon_idx < 0 && exp_q[i][W-1:12] == ch_out) mon_idx = i;
        if (mon_idx < 0) begin
          chk("sb_unexpected_valid", 32'(valid), 32'd0);
        end else begin
          chk("sb_wi", 32'(wi_out), 32'(exp_q[mon_idx][11:0]));
          chk("sb_ack_onehot", 32'(ack), 32'd1 << ch_out);
          exp_q.delete(mon_idx);
          ack_log.push_back(int'(ch_out));
        end
      end else begin
        chk("sb_idle_ack", 32'(ack), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int k, input logic [4:0] code);
    i_bus_a[k] = code;
    req_a[k]   = 1'b1;
    exp_q.push_back({CHW'(k), lut(rate_model[k], code)});
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] rate);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_rate = rate;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    rate_model[ch] = rate;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) rate_model[k] = 2'b00;
  endtask

  // One isolated request with cycle-exact checks of latency and outputs.
  task automatic single(input int k, input logic [4:0] code, input logic [11:0] exp_wi,
                        input string nm);
    @(posedge clk); #1;
    drive_req(k, code);
    repeat (2) @(negedge clk);
    chk({nm, "_f_i"}, 32'(f_i), 32'(code));
    chk({nm, "_f_rate"}, 32'(f_rate), 32'(rate_model[k]));
    chk({nm, "_busy_s1"}, 32'(busy), 32'd1);
    chk({nm, "_valid_early"}, 32'(valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_ack"}, 32'(ack), 32'd1 << k);
    chk({nm, "_ch_out"}, 32'(ch_out), 32'(k));
    chk({nm, "_wi_out"}, 32'(wi_out), 32'(exp_wi));
    @(posedge clk); #1;
    req_a[k] = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_valid_end"}, 32'(valid), 32'd0);
  endtask

  // Protocol-following channel: raise, hold until ACK, drop next cycle.
  task automatic chan_driver(input int k, input int n, input int idle_max);
    int cnt;
    for (int r = 0; r < n; r++) begin
      @(posedge clk); #1;
      drive_req(k, 5'($urandom_range(0, 31)));
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!ack[k] && cnt < 40);
      chk("ack_within_bound", 32'(ack[k]), 32'd1);
      @(posedge clk); #1;
      req_a[k] = 1'b0;
      repeat ($urandom_range(0, idle_max)) @(posedge clk);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_rate = '0;
    for (int k = 0; k < NCH; k++) begin
      req_a[k] = 1'b0; i_bus_a[k] = '0; rate_model[k] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_f_i", 32'(f_i), 32'd0);
    chk("rst_f_rate", 32'(f_rate), 32'd0);
    chk("rst_wi_out", 32'(wi_out), 32'd0);
    chk("rst_ch_out", 32'(ch_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, 40k table.
    single(0, 5'd15, 12'd696, "t1_ch0_i15");

    // Rate config and sign folding.
    cfg_write(2, 2'b01);
    single(2, 5'd8, 12'd1122, "t2_r32_i8");
    single(2, 5'd7, 12'd1122, "t2_r32_i7");
    cfg_write(2, 2'b11);
    single(2, 5'd0, 12'd4074, "t2_r16_i0");

    // Config write on the same edge as the grant uses the old rate.
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_rate = 2'b11;
    drive_req(0, 5'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    rate_model[0] = 2'b11;
    @(negedge clk);
    chk("t4_same_edge_f_rate", 32'(f_rate), 32'd0);
    @(negedge clk);
    chk("t4_same_edge_valid", 32'(valid), 32'd1);
    chk("t4_same_edge_wi", 32'(wi_out), 32'd14);
    @(posedge clk); #1;
    req_a[0] = 1'b0;
    single(0, 5'd1, 12'd439, "t4_new_rate");

    // Back-to-back: ch1 then ch3 on consecutive cycles.
    apply_reset();
    cfg_write(1, 2'b10);
    cfg_write(3, 2'b10);
    @(posedge clk); #1;
    drive_req(1, 5'd3);
    drive_req(3, 5'd1);
    repeat (2) @(negedge clk);
    chk("t5_busy_1", 32'(busy), 32'd1);
    chk("t5_f_i_ch1", 32'(f_i), 32'd3);
    @(negedge clk);
    chk("t5_valid_a", 32'(valid), 32'd1);
    chk("t5_ch_a", 32'(ch_out), 32'd1);
    chk("t5_wi_a", 32'(wi_out), 32'd582);
    chk("t5_busy_2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    req_a[1] = 1'b0;
    @(negedge clk);
    chk("t5_valid_b", 32'(valid), 32'd1);
    chk("t5_ch_b", 32'(ch_out), 32'd3);
    chk("t5_wi_b", 32'(wi_out), 32'd30);
    chk("t5_busy_3", 32'(busy), 32'd1);
    @(posedge clk); #1;
    req_a[3] = 1'b0;
    @(negedge clk);
    chk("t5_busy_low", 32'(busy), 32'd0);
    chk("t5_valid_low", 32'(valid), 32'd0);

    // Round-robin fairness with all channels re-requesting immediately.
    apply_reset();
    for (int k = 0; k < NCH; k++) cfg_write(k, 2'($urandom_range(0, 3)));
    ack_log.delete();
    fork
      chan_driver(0, 3, 0);
      chan_driver(1, 3, 0);
      chan_driver(2, 3, 0);
      chan_driver(3, 3, 0);
    join
    chk("t3_ack_count", 32'(ack_log.size()), 32'(3 * NCH));
    foreach (ack_log[i]) chk("t3_rr_order", 32'(ack_log[i]), 32'(i % NCH));

    // Reset one cycle after a grant: no ACK, regrant from ch0 after release.
    @(posedge clk); #1;
    i_bus_a[0] = 5'd5; req_a[0] = 1'b1;
    i_bus_a[2] = 5'd9; req_a[2] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_f_i", 32'(f_i), 32'd0);
    chk("t6_rst_f_rate", 32'(f_rate), 32'd0);
    chk("t6_rst_wi", 32'(wi_out), 32'd0);
    chk("t6_rst_ch", 32'(ch_out), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) rate_model[k] = 2'b00;
    exp_q.push_back({CHW'(0), lut(2'b00, 5'd5)});
    exp_q.push_back({CHW'(2), lut(2'b00, 5'd9)});
    repeat (2) @(negedge clk);
    chk("t6_restart_f_i", 32'(f_i), 32'd5);
    @(negedge clk);
    chk("t6_restart_valid", 32'(valid), 32'd1);
    chk("t6_restart_ch0", 32'(ch_out), 32'd0);
    @(posedge clk); #1;
    req_a[0] = 1'b0;
    @(negedge clk);
    chk("t6_second_ch2", 32'(ch_out), 32'd2);
    @(posedge clk); #1;
    req_a[2] = 1'b0;

    // Randomised traffic with random rates.
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < NCH; k++) cfg_write(k, 2'($urandom_range(0, 3)));
      fork
        chan_driver(0, 6, 3);
        chan_driver(1, 6, 3);
        chan_driver(2, 6, 3);
        chan_driver(3, 6, 3);
      join
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
